// File: rtl/led_key_ctrl_if.sv
// Front-panel bus between the push buttons and the PWM-facing control
// registers: raw keys in, press pulses and display settings out.
interface led_key_ctrl_if;
   logic [1:0] KEY;
   logic [1:0] KEY_PRESS;
   logic [1:0] MODE;
   logic       MODE_CHG;
   logic [5:0] LEVEL;
   logic       LEVEL_CHG;

   // Design side: consumes raw keys, produces settings.
   modport slave  (input  KEY,
                   output KEY_PRESS, MODE, MODE_CHG, LEVEL, LEVEL_CHG);

   // Environment side: drives keys, observes settings.
   modport master (output KEY,
                   input  KEY_PRESS, MODE, MODE_CHG, LEVEL, LEVEL_CHG);
endinterface

// File: rtl/led_key_ctrl.sv
// Front-panel control: synchronizes and debounces the two push buttons,
// emits one pulse per accepted press, and keeps the MODE and LEVEL
// registers that feed the LED PWM stage.
module led_key_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int LEVEL_STEP      = 8,
   parameter int LEVEL_INIT      = 32
) (
   input  logic          CLK50M,
   input  logic          RESET,
   led_key_ctrl_if.slave bus
);
   localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } dbnc_state_t;

   logic [1:0] r_sync1;
   logic [1:0] r_sync2;
   logic [1:0] w_key_press;
   logic [5:0] r_level;
   logic [1:0] r_mode;
   logic       r_level_chg;
   logic       r_mode_chg;

   // Next brightness: wrap from full scale to zero, otherwise step and
   // saturate. The 7-bit sum keeps the carry visible for saturation.
   function automatic logic [5:0] next_level(input logic [5:0] cur);
      logic [6:0] sum;
      sum = {1'b0, cur} + 7'(LEVEL_STEP);
      if (cur == 6'd63) begin
         next_level = 6'd0;
      end else if (sum > 7'd63) begin
         next_level = 6'd63;
      end else begin
         next_level = sum[5:0];
      end
   endfunction

   // Two-flop synchronizer; released (1) is the safe reset level.
   always_ff @(posedge CLK50M or posedge RESET) begin
      if (RESET) begin
         r_sync1 <= 2'b11;
         r_sync2 <= 2'b11;
      end else begin
         r_sync1 <= bus.KEY;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_dbnc
      dbnc_state_t   r_state;
      dbnc_state_t   w_state_nxt;
      logic [CW-1:0] r_cnt;
      logic [CW-1:0] w_cnt_nxt;
      logic          w_press_nxt;
      logic          r_press;
      logic          w_down;

      assign w_down = ~r_sync2[g];

      // Debounce next-state: any opposite sample in a wait state falls back
      // to the stable state it came from.
      always_comb begin
         w_state_nxt = r_state;
         w_cnt_nxt   = r_cnt;
         w_press_nxt = 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_down) begin
                  w_state_nxt = ST_PRESS_WAIT;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_PRESS_WAIT: begin
               if (!w_down) begin
                  w_state_nxt = ST_IDLE;
               end else if (r_cnt == CNT_LAST) begin
                  w_state_nxt = ST_PRESSED;
                  w_press_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            ST_PRESSED: begin
               if (!w_down) begin
                  w_state_nxt = ST_RELEASE_WAIT;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = ST_PRESSED;
               end
            end
            ST_RELEASE_WAIT: begin
               if (w_down) begin
                  w_state_nxt = ST_PRESSED;
               end else if (r_cnt == CNT_LAST) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end

      // Debounce state, counter and registered press pulse.
      always_ff @(posedge CLK50M or posedge RESET) begin
         if (RESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_press <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_press <= w_press_nxt;
         end
      end

      assign w_key_press[g] = r_press;
   end

   // Settings registers: KEY0 steps brightness, KEY1 cycles mode; change
   // flags rise on the same edge the new value appears.
   always_ff @(posedge CLK50M or posedge RESET) begin
      if (RESET) begin
         r_level     <= 6'(LEVEL_INIT);
         r_mode      <= 2'd0;
         r_level_chg <= 1'b0;
         r_mode_chg  <= 1'b0;
      end else begin
         r_level_chg <= w_key_press[0];
         r_mode_chg  <= w_key_press[1];
         if (w_key_press[0]) begin
            r_level <= next_level(r_level);
         end else begin
            r_level <= r_level;
         end
         if (w_key_press[1]) begin
            r_mode <= r_mode + 2'd1;
         end else begin
            r_mode <= r_mode;
         end
      end
   end

   assign bus.KEY_PRESS = w_key_press;
   assign bus.LEVEL     = r_level;
   assign bus.MODE      = r_mode;
   assign bus.LEVEL_CHG = r_level_chg;
   assign bus.MODE_CHG  = r_mode_chg;
endmodule

// File: tb/tb_led_key_ctrl.sv
// Directed bench for led_key_ctrl with a short debounce window (4 cycles).
// Observed vector = {KEY_PRESS, MODE_CHG, LEVEL_CHG, MODE, LEVEL}.
module tb_led_key_ctrl;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;
   logic [5:0] cur_level;
   logic [1:0] cur_mode;

   led_key_ctrl_if bus();

   led_key_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
      .CLK50M (clk),
      .RESET  (rst),
      .bus    (bus)
   );

   // 50 MHz clock
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   function automatic logic [11:0] obs();
      return {bus.KEY_PRESS, bus.MODE_CHG, bus.LEVEL_CHG, bus.MODE, bus.LEVEL};
   endfunction

   function automatic logic [11:0] pack(input logic [1:0] kp, input logic mc,
                                        input logic lc, input logic [1:0] m,
                                        input logic [5:0] l);
      return {kp, mc, lc, m, l};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      bus.KEY = 2'b11;
      #1;
      chk("reset_async", 32'(obs()), 32'(pack(2'b00, 1'b0, 1'b0, 2'd0, 6'd32)));
      repeat (3) tick();
      chk("reset_hold", 32'(obs()), 32'(pack(2'b00, 1'b0, 1'b0, 2'd0, 6'd32)));
      rst       = 1'b0;
      cur_level = 6'd32;
      cur_mode  = 2'd0;
   endtask

   // Press keys k (1 = pressed) for 'hold' edges, then release for 12 edges,
   // checking every edge. nl/nm are the hand-computed settings after the press.
   task automatic do_press(input string tag, input logic [1:0] k, input int hold,
                           input logic [5:0] nl, input logic [1:0] nm);
      logic [11:0] e_v;
      bus.KEY = ~k;
      for (int e = 1; e <= hold; e++) begin
         tick();
         e_v = pack((e == 7) ? k : 2'b00,
                    (e == 8) && k[1], (e == 8) && k[0],
                    (e >= 8) ? nm : cur_mode, (e >= 8) ? nl : cur_level);
         chk($sformatf("%s_e%0d", tag, e), 32'(obs()), 32'(e_v));
      end
      bus.KEY = 2'b11;
      for (int e = 1; e <= 12; e++) begin
         tick();
         chk($sformatf("%s_rel%0d", tag, e), 32'(obs()),
             32'(pack(2'b00, 1'b0, 1'b0, nm, nl)));
      end
      cur_level = nl;
      cur_mode  = nm;
   endtask

   initial begin
      logic [5:0] wrap_tbl [8];
      logic [1:0] mode_tbl [4];
      int         pulses;
      wrap_tbl = '{6'd40, 6'd48, 6'd56, 6'd63, 6'd0, 6'd8, 6'd16, 6'd24};
      mode_tbl = '{2'd2, 2'd3, 2'd0, 2'd1};
      n_chk  = 0;
      n_fail = 0;
      pulses = 0;

      // Reset and idle
      do_reset();
      for (int i = 0; i < 100; i++) begin
         tick();
         if (bus.KEY_PRESS != 2'b00 || bus.MODE_CHG || bus.LEVEL_CHG) pulses++;
      end
      chk("idle_pulses", 32'(pulses), 32'd0);
      chk("idle_state", 32'(obs()), 32'(pack(2'b00, 1'b0, 1'b0, 2'd0, 6'd32)));

      // Clean KEY0 press held 50 cycles
      do_press("clean0", 2'b01, 50, 6'd40, 2'd0);

      // Level wrap from reset
      do_reset();
      for (int i = 0; i < 8; i++)
         do_press($sformatf("wrap%0d", i), 2'b01, 10, wrap_tbl[i], 2'd0);

      // Bounce on KEY1: 3 low, 1 high, 3 low, then released
      bus.KEY = 2'b01; repeat (3) tick();
      bus.KEY = 2'b11; tick();
      bus.KEY = 2'b01;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("bounce_lo%0d", i), 32'(obs()),
             32'(pack(2'b00, 1'b0, 1'b0, 2'd0, 6'd24)));
      end
      bus.KEY = 2'b11;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk($sformatf("bounce_rel%0d", i), 32'(obs()),
             32'(pack(2'b00, 1'b0, 1'b0, 2'd0, 6'd24)));
      end

      // Clean KEY1 presses: 1, then 2, 3, 0, 1
      do_press("mode_first", 2'b10, 10, 6'd24, 2'd1);
      for (int i = 0; i < 4; i++)
         do_press($sformatf("mode%0d", i), 2'b10, 10, 6'd24, mode_tbl[i]);

      // Simultaneous press: MODE 1->2, LEVEL 24->32
      do_press("both", 2'b11, 10, 6'd32, 2'd2);
      do_press("pre_rst", 2'b01, 10, 6'd40, 2'd2);

      // Reset at edge 5 of a KEY0 press, key held through deassertion
      bus.KEY = 2'b10;
      repeat (5) tick();
      rst = 1'b1;
      #1;
      chk("midrst_async", 32'(obs()), 32'(pack(2'b00, 1'b0, 1'b0, 2'd0, 6'd32)));
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("midrst_hold%0d", i), 32'(obs()),
             32'(pack(2'b00, 1'b0, 1'b0, 2'd0, 6'd32)));
      end
      rst       = 1'b0;
      cur_level = 6'd32;
      cur_mode  = 2'd0;
      do_press("after_rst", 2'b01, 10, 6'd40, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
